// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control word layout, ALU selects and
// R-type decode tables used by both ID and EX.
package mips_pkg;

  localparam int unsigned CTRL_W         = 11;
  localparam int unsigned CLASS_W        = 3;
  localparam int unsigned ALU_W          = 4;
  localparam int unsigned FUNCT_W        = 6;
  localparam int unsigned CTRL_REGWRITE  = 10;
  localparam int unsigned CTRL_CLASS_LSB = 3;

  localparam logic [CTRL_W-1:0] BUBBLE = 11'h038;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_NOR = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_SLL = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN_SRA = 6'b000011;

  typedef enum logic [CLASS_W-1:0] {
    CLASS_ALU    = 3'b000,
    CLASS_SHIFT  = 3'b100,
    CLASS_BUBBLE = 3'b111
  } class_e;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1000,
    ALU_SLL = 4'b1001,
    ALU_SRA = 4'b1010
  } alu_e;

  typedef struct packed {
    logic   valid;
    class_e cls;
    alu_e   alu;
    logic   swap;
  } funct_dec_t;

  // R-type funct lookup; swap routes rt to operand 1 so EX's (rd2<rd1) means rs<rt.
  function automatic funct_dec_t decode_funct(input logic [FUNCT_W-1:0] funct);
    funct_dec_t d;
    d.valid = 1'b1;
    d.cls   = CLASS_ALU;
    d.alu   = ALU_AND;
    d.swap  = 1'b0;
    case (funct)
      FN_ADD:  d.alu = ALU_ADD;
      FN_SUB:  d.alu = ALU_SUB;
      FN_AND:  d.alu = ALU_AND;
      FN_OR:   d.alu = ALU_OR;
      FN_NOR:  d.alu = ALU_NOR;
      FN_SLT:  begin d.alu = ALU_SLT; d.swap = 1'b1; end
      FN_SLL:  begin d.alu = ALU_SLL; d.cls = CLASS_SHIFT; end
      FN_SRA:  begin d.alu = ALU_SRA; d.cls = CLASS_SHIFT; end
      default: begin d.valid = 1'b0; d.cls = CLASS_BUBBLE; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// Register file: two write-first read ports, one write port, R[0] hardwired to zero.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SIZE)-1:0] raddr1,
  input  logic [$clog2(SIZE)-1:0] raddr2,
  output logic [SIZE-1:0]         rdata1_c,
  output logic [SIZE-1:0]         rdata2_c,
  input  logic                    we,
  input  logic [$clog2(SIZE)-1:0] waddr,
  input  logic [SIZE-1:0]         wdata
);

  localparam int unsigned IDX_W = $clog2(SIZE);

  logic [SIZE-1:0] mem_q [SIZE];
  logic [SIZE-1:0] mem_d [SIZE];
  logic            wr_hit;

  assign wr_hit = we && (waddr != '0);

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SIZE); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Write-first bypass so a same-cycle write-back is visible to the reader.
  function automatic logic [SIZE-1:0] rd_port(input logic [IDX_W-1:0] a);
    if (a == '0)                 return '0;
    else if (wr_hit && a == waddr) return wdata;
    else                         return mem_q[a];
  endfunction

  always_comb begin
    rdata1_c = rd_port(raddr1);
    rdata2_c = rd_port(raddr2);
  end

endmodule

// File: rtl/id_stage_decode.sv
// ID stage: R-type decode, register-file read and one-cycle RAW stall,
// registering operands and control toward EX.
module id_stage_decode
  import mips_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr,
  input  logic                    instr_valid,
  input  logic [SIZE-1:0]         PC_4_IF,
  input  logic                    wb_en,
  input  logic [$clog2(SIZE)-1:0] wb_reg,
  input  logic [SIZE-1:0]         wb_data,
  output logic [SIZE-1:0]         readData1,
  output logic [SIZE-1:0]         readData2,
  output logic [$clog2(SIZE)-1:0] shamt,
  output logic [$clog2(SIZE)-1:0] writeReg,
  output logic [CTRL_W-1:0]       control,
  output logic [ALU_W-1:0]        ALUcontrol,
  output logic [SIZE-1:0]         PC_4_ID,
  output logic                    stall
);

  localparam int unsigned IDX_W = $clog2(SIZE);

  logic [5:0]         opcode;
  logic [IDX_W-1:0]   rs, rt, rd, sh;
  logic [SIZE-1:0]    rs_data, rt_data;
  funct_dec_t         dec;
  logic               decodable, issue, stall_c;

  logic [SIZE-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, pc_4_q, pc_4_d;
  logic [IDX_W-1:0]   shamt_q, shamt_d, wreg_q, wreg_d, trk_reg_q, trk_reg_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [ALU_W-1:0]   alu_q, alu_d;
  logic               trk_we_q, trk_we_d;

  assign opcode = instr[31:26];
  assign rs     = IDX_W'(instr[25:21]);
  assign rt     = IDX_W'(instr[20:16]);
  assign rd     = IDX_W'(instr[15:11]);
  assign sh     = IDX_W'(instr[10:6]);

  mips_regfile #(.SIZE(SIZE)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (rs),
    .raddr2   (rt),
    .rdata1_c (rs_data),
    .rdata2_c (rt_data),
    .we       (wb_en),
    .waddr    (wb_reg),
    .wdata    (wb_data)
  );

  always_comb begin
    dec       = decode_funct(instr[5:0]);
    decodable = instr_valid && (opcode == OPC_RTYPE) && dec.valid;
    // Tracker only ever holds a RegWrite with rd!=0, so $0 never stalls.
    stall_c   = decodable && trk_we_q && ((trk_reg_q == rs) || (trk_reg_q == rt));
    issue     = decodable && !stall_c;

    pc_4_d    = PC_4_IF;
    ctrl_d    = BUBBLE;
    alu_d     = '0;
    rd1_d     = '0;
    rd2_d     = '0;
    shamt_d   = '0;
    wreg_d    = '0;
    trk_we_d  = 1'b0;
    trk_reg_d = '0;

    if (issue) begin
      ctrl_d                                 = '0;
      ctrl_d[CTRL_REGWRITE]                  = (rd != '0);
      ctrl_d[CTRL_CLASS_LSB +: CLASS_W]      = dec.cls;
      alu_d                                  = dec.alu;
      rd1_d                                  = dec.swap ? rt_data : rs_data;
      rd2_d                                  = dec.swap ? rs_data : rt_data;
      shamt_d                                = sh;
      wreg_d                                 = rd;
      trk_we_d                               = (rd != '0);
      trk_reg_d                              = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_q     <= '0;
      rd2_q     <= '0;
      shamt_q   <= '0;
      wreg_q    <= '0;
      ctrl_q    <= BUBBLE;
      alu_q     <= '0;
      pc_4_q    <= '0;
      trk_we_q  <= 1'b0;
      trk_reg_q <= '0;
    end else begin
      rd1_q     <= rd1_d;
      rd2_q     <= rd2_d;
      shamt_q   <= shamt_d;
      wreg_q    <= wreg_d;
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      pc_4_q    <= pc_4_d;
      trk_we_q  <= trk_we_d;
      trk_reg_q <= trk_reg_d;
    end
  end

  assign readData1  = rd1_q;
  assign readData2  = rd2_q;
  assign shamt      = shamt_q;
  assign writeReg   = wreg_q;
  assign control    = ctrl_q;
  assign ALUcontrol = alu_q;
  assign PC_4_ID    = pc_4_q;
  assign stall      = stall_c;

endmodule

// File: tb/tb_id_stage_decode.sv
// Directed bench for id_stage_decode: decode, operand routing, write-back
// bypass, RAW stall and reset behaviour.
module tb_id_stage_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] PC_4_IF;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] readData1, readData2, PC_4_ID;
  logic [4:0]  shamt, writeReg;
  logic [10:0] control;
  logic [3:0]  ALUcontrol;
  logic        stall;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_stage_decode #(.SIZE(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .PC_4_IF     (PC_4_IF),
    .wb_en       (wb_en),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .readData1   (readData1),
    .readData2   (readData2),
    .shamt       (shamt),
    .writeReg    (writeReg),
    .control     (control),
    .ALUcontrol  (ALUcontrol),
    .PC_4_ID     (PC_4_ID),
    .stall       (stall)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; PC_4_IF = 32'h0000_0004;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    step();
    rst = 1'b0;
    chk("rst_control", 32'(control), 32'h038);
    chk("rst_alu", 32'(ALUcontrol), 32'h0);
    chk("rst_pc", PC_4_ID, 32'h0);
    #1;
    chk("rst_stall", 32'(stall), 32'h0);

    // read R5 twice after reset
    instr = rtype(5, 5, 8, 0, 6'b100000); instr_valid = 1'b1; PC_4_IF = 32'h8;
    step();
    chk("r5_rd1", readData1, 32'h0);
    chk("r5_rd2", readData2, 32'h0);

    // back-to-back write-back R1=7, R2=3 with bubbles in ID
    instr_valid = 1'b0; wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'd7;
    step();
    chk("bubble_control", 32'(control), 32'h038);
    wb_reg = 5'd2; wb_data = 32'd3;
    step();
    wb_en = 1'b0;

    // add $3,$1,$2
    instr = rtype(1, 2, 3, 0, 6'b100000); instr_valid = 1'b1; PC_4_IF = 32'h10;
    #1;
    chk("add_stall", 32'(stall), 32'h0);
    step();
    chk("add_rd1", readData1, 32'd7);
    chk("add_rd2", readData2, 32'd3);
    chk("add_alu", 32'(ALUcontrol), 32'h2);
    chk("add_control", 32'(control), 32'h400);
    chk("add_wreg", 32'(writeReg), 32'd3);
    chk("add_pc", PC_4_ID, 32'h10);

    // R1=2 during a bubble, then slt $4,$1,$2 with R2=9 bypassed in same cycle
    instr_valid = 1'b0; wb_en = 1'b1; wb_reg = 5'd1; wb_data = 32'd2;
    step();
    instr = rtype(1, 2, 4, 0, 6'b101010); instr_valid = 1'b1;
    wb_reg = 5'd2; wb_data = 32'd9;
    step();
    wb_en = 1'b0;
    chk("slt_rd1", readData1, 32'd9);
    chk("slt_rd2", readData2, 32'd2);
    chk("slt_alu", 32'(ALUcontrol), 32'h7);
    chk("slt_wreg", 32'(writeReg), 32'd4);

    // RAW: add $3,$1,$2 then sub $5,$3,$1
    instr_valid = 1'b0;
    step();
    instr = rtype(1, 2, 3, 0, 6'b100000); instr_valid = 1'b1;
    step();
    instr = rtype(3, 1, 5, 0, 6'b100010); PC_4_IF = 32'h20;
    #1;
    chk("raw_stall", 32'(stall), 32'h1);
    step();
    chk("raw_bubble_control", 32'(control), 32'h038);
    chk("raw_bubble_alu", 32'(ALUcontrol), 32'h0);
    chk("raw_pc", PC_4_ID, 32'h20);
    wb_en = 1'b1; wb_reg = 5'd3; wb_data = 32'd10; PC_4_IF = 32'h24;
    #1;
    chk("raw_stall_clear", 32'(stall), 32'h0);
    step();
    wb_en = 1'b0;
    chk("sub_rd1", readData1, 32'd10);
    chk("sub_rd2", readData2, 32'd2);
    chk("sub_alu", 32'(ALUcontrol), 32'h6);
    chk("sub_control", 32'(control), 32'h400);
    chk("sub_pc", PC_4_ID, 32'h24);

    // sll $6,$0,$2 by 4
    instr = rtype(0, 2, 6, 4, 6'b000000);
    #1;
    chk("sll_stall", 32'(stall), 32'h0);
    step();
    chk("sll_shamt", 32'(shamt), 32'd4);
    chk("sll_control", 32'(control), 32'h420);
    chk("sll_alu", 32'(ALUcontrol), 32'h9);
    chk("sll_rd2", readData2, 32'd9);

    // non-R-type reading $6 must neither stall nor decode
    instr = {6'h23, 5'd6, 5'd7, 16'h0000};
    #1;
    chk("lw_stall", 32'(stall), 32'h0);
    step();
    chk("lw_control", 32'(control), 32'h038);
    chk("lw_alu", 32'(ALUcontrol), 32'h0);
    instr = rtype(6, 6, 9, 0, 6'b100000);
    #1;
    chk("after_lw_stall", 32'(stall), 32'h0);
    step();
    chk("after_lw_control", 32'(control), 32'h400);

    // add $0,$1,$2 then add $7,$0,$0 with an attempted write to $0
    instr = rtype(1, 2, 0, 0, 6'b100000);
    step();
    chk("rd0_control", 32'(control), 32'h000);
    instr = rtype(0, 0, 7, 0, 6'b100000);
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'd55;
    #1;
    chk("rd0_dep_stall", 32'(stall), 32'h0);
    step();
    wb_en = 1'b0;
    chk("r0_rd1", readData1, 32'h0);
    chk("r0_rd2", readData2, 32'h0);
    chk("r0_control", 32'(control), 32'h400);

    // reset during a stall
    instr = rtype(1, 2, 3, 0, 6'b100000);
    step();
    instr = rtype(3, 1, 5, 0, 6'b100010);
    #1;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_control", 32'(control), 32'h038);
    #1;
    chk("rst2_stall", 32'(stall), 32'h0);
    step();
    chk("rst2_rd1", readData1, 32'h0);
    chk("rst2_rd2", readData2, 32'h0);
    chk("rst2_control_sub", 32'(control), 32'h400);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/id_stage_decode.md
Name: id_stage_decode

Overview:
- Instruction-decode stage of the 4-stage MIPS pipeline (IF, ID, EX, WB).
- Producer side of the ID→EX interface: decodes R-type instructions and reads the register file.
- Registers readData1, readData2, shamt, writeReg, control, ALUcontrol and PC_4_ID toward EX.
- Owns the register file, its write-back port, and one-cycle RAW hazard stalling.

Parameters:
- SIZE, 32, datapath width and register count; register index width is $clog2(SIZE).

Ports:
- clk  in  1  processor clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  instruction from IF; held stable by IF while stall=1.
- instr_valid  in  1  instr is a real instruction; 0 means decode as bubble.
- PC_4_IF  in  SIZE  PC+4 from IF.
- wb_en  in  1  write-back enable from WB.
- wb_reg  in  $clog2(SIZE)  write-back register index.
- wb_data  in  SIZE  write-back data.
- readData1  out  SIZE  registered operand 1.
- readData2  out  SIZE  registered operand 2.
- shamt  out  $clog2(SIZE)  registered instr[10:6].
- writeReg  out  $clog2(SIZE)  registered destination (rd).
- control  out  11  registered control word.
- ALUcontrol  out  4  registered ALU select.
- PC_4_ID  out  SIZE  registered PC+4.
- stall  out  1  combinational; 1 = IF must hold instr this cycle.

Behaviour:
- Control word layout:
  - [10] RegWrite.
  - [5:3] class: 000 = R-type ALU, 100 = R-type shift, 111 = bubble.
  - All other bits 0.
  - BUBBLE = 11'h038.
- Reset (rst=1 at posedge):
  - All 32 registers cleared.
  - readData1, readData2, shamt, writeReg, ALUcontrol, PC_4_ID = 0.
  - control = BUBBLE. Reset must not yield 0, which EX executes as an add.
  - Hazard tracker cleared.
  - rst has priority over wb_en and decode.
- Decode (opcode instr[31:26] = 0), funct → ALUcontrol/class:
  - add 100000 → 0010/000
  - sub 100010 → 0110/000
  - and 100100 → 0000/000
  - or 100101 → 0001/000
  - nor 100111 → 1000/000
  - slt 101010 → 0111/000
  - sll 000000 → 1001/100
  - sra 000011 → 1010/100
- Any other opcode/funct, or instr_valid=0: control=BUBBLE, ALUcontrol=0.
- Operand routing:
  - Default: readData1=R[rs], readData2=R[rt].
  - slt: swapped, readData1=R[rt], readData2=R[rs], so EX's (rd2<rd1) yields rs<rt.
  - Shifts: readData2=R[rt], readData1=R[rs] (don't-care).
- writeReg=rd.
  - RegWrite=1 for decoded instructions with rd≠0.
  - RegWrite=0 for rd=0 and for bubbles.
- Latency: one cycle, instr at posedge n → outputs valid after posedge n.
- Register file:
  - Write at posedge when wb_en=1 and wb_reg≠0.
  - R[0] always reads 0.
  - Same-cycle bypass: a read of wb_reg while wb_en=1 returns wb_data (write-first), except register 0.
- Hazard tracker:
  - Holds {RegWrite, writeReg} of the instruction currently in EX, i.e. the last issued by ID.
  - stall=1 when the tracked RegWrite=1 and the tracked reg equals rs or rt of the current valid decodable instruction.
  - While stall=1: outputs take BUBBLE (control=11'h038), PC_4_ID still updates, tracker loads RegWrite=0.
  - Next cycle stall clears and the held instr decodes, reading the value via the write-back bypass.
- A dependency on rd=0 never stalls.
- rst during stall: reset wins, stall deasserts next cycle.

Decomposition:
- Package mips_pkg:
  - CTRL_W=11, BUBBLE=11'h038.
  - Class codes, ALUcontrol codes, funct codes, control-bit indices.
  - Must also be used by EX.
- Sub-module mips_regfile: 2 read ports, 1 write port, write-first bypass, synchronous reset, R[0]=0.

Test Plan:
- Reset → control=11'h038, ALUcontrol=0, stall=0; readData of R5 = 0.
- wb R1=7, R2=3 (back-to-back wb, no dependency), then add $3,$1,$2 → readData1=7, readData2=3, ALUcontrol=0010, control=11'h400, writeReg=3.
- slt $4,$1,$2 with R1=2, R2=9 → readData1=9, readData2=2, ALUcontrol=0111.
- add $3,$1,$2 then sub $5,$3,$1:
  - Cycle 2: stall=1, control=11'h038.
  - Cycle 3, with wb_en=1, wb_reg=3, wb_data=10: sub issues with readData1=10.
- sll $6,$0,$2 with instr[10:6]=4 → shamt=4, control=11'h420, ALUcontrol=1001. Then opcode 0x23 → control=11'h038, no stall on the next instruction.
- add $0,$1,$2 then add $7,$0,$0 → no stall; control[10]=0 on the first; readData1=readData2=0 on the second.
